// File: rtl/syn_updown_mod_counter.sv
// syn_updown_mod_counter: synchronous up/down counter with programmable modulus,
// count enable, direction control, parallel load (clamped to MOD-1), a
// combinational terminal-count flag and a registered wrap pulse.
// Optional feature macro: SYN_UPDOWN_CNT_SAT_EN. When it is defined the counter
// saturates at its limits instead of wrapping.
module syn_updown_mod_counter #(
    parameter int BITS = 5,
    parameter int MOD  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            up_dn,
    input  logic            load,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] Q,
    output logic            tc,
    output logic            wrap
);

    // Reject illegal configurations at elaboration
    if (BITS < 2 || BITS > 16) begin : g_bad_bits
        $error("syn_updown_mod_counter: BITS must be 2..16");
    end
    if (MOD < 2 || MOD > (1 << BITS)) begin : g_bad_mod
        $error("syn_updown_mod_counter: MOD must be 2..2**BITS");
    end

    // Top count value, truncated to the register width so MOD == 2**BITS works
    localparam logic [BITS-1:0] MAX = BITS'(MOD - 1);

    logic            at_max;
    logic            at_zero;
    logic [BITS-1:0] q_inc;
    logic [BITS-1:0] q_dec;
    logic [BITS-1:0] q_nxt;
    logic            wrap_nxt;

    assign at_max  = (Q == MAX);
    assign at_zero = (Q == '0);
    assign q_inc   = Q + BITS'(1);
    assign q_dec   = Q - BITS'(1);

    // High in the cycle before a wrap so the next cascaded stage can use it as en
    assign tc = en & ((up_dn & at_max) | (~up_dn & at_zero));

    // Next-state selection: load beats enable, enable beats hold
    always_comb begin
        q_nxt    = Q;
        wrap_nxt = 1'b0;
        if (load) begin
            q_nxt = (d > MAX) ? MAX : d;
        end else if (en) begin
            if (up_dn) begin
`ifdef SYN_UPDOWN_CNT_SAT_EN
                // Pulse only on the step that lands on the limit, then hold
                if (!at_max) begin
                    q_nxt    = q_inc;
                    wrap_nxt = (q_inc == MAX);
                end
`else
                if (at_max) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q_inc;
                end
`endif
            end else begin
`ifdef SYN_UPDOWN_CNT_SAT_EN
                if (!at_zero) begin
                    q_nxt    = q_dec;
                    wrap_nxt = (q_dec == '0);
                end
`else
                if (at_zero) begin
                    q_nxt    = MAX;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q_dec;
                end
`endif
            end
        end
    end

    // Count and wrap registers; reset clears both without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else begin
            Q    <= q_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule
